event_irq_ctrl: RTL and testbench

//  APB-programmable event/interrupt collector directly upstream of the sleep unit.

---
 rtl/event_irq_ctrl_if.sv | 25 ++
 rtl/event_irq_ctrl.sv | 113 +++++++++++
 tb/tb_event_irq_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/event_irq_ctrl_if.sv
// APB slave bus bundle for the event/interrupt collector.
interface event_irq_ctrl_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12
);
    localparam int unsigned DATA_W = 32;

    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/event_irq_ctrl.sv
// Event/interrupt collector: edge-detects event lines into a pending register,
// drives a masked irq level, a masked event pulse and a lowest-index interrupt ID.
module event_irq_ctrl #(
    parameter int unsigned  APB_ADDR_WIDTH = 12,
    parameter int unsigned  NUM_EVENTS     = 32,
    localparam int unsigned ID_W           = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    event_irq_ctrl_if.slave       apb,
    input  logic [NUM_EVENTS-1:0] events_i,
    input  logic                  irq_ack_i,
    input  logic [ID_W-1:0]       irq_id_i,
    output logic                  irq_o,
    output logic [ID_W-1:0]       irq_id_o,
    output logic                  event_o
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned PAD_W  = DATA_W - 1 - 8;

    localparam logic [IDX_W-1:0] A_IRQ_MASK = 3'd0;
    localparam logic [IDX_W-1:0] A_EVT_MASK = 3'd1;
    localparam logic [IDX_W-1:0] A_PENDING  = 3'd2;
    localparam logic [IDX_W-1:0] A_SET      = 3'd3;
    localparam logic [IDX_W-1:0] A_IRQ_ID   = 3'd4;

    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [IDX_W-1:0]          idx;
    logic                      acc_wr;
    logic                      acc_rd;
    logic [NUM_EVENTS-1:0]     wdata;
    logic [DATA_W-1:0]         rdata;
    logic                      unused_apb;

    logic [NUM_EVENTS-1:0] evt_q;
    logic [NUM_EVENTS-1:0] pending_q;
    logic [NUM_EVENTS-1:0] irq_mask_q;
    logic [NUM_EVENTS-1:0] evt_mask_q;
    logic                  event_q;

    logic [NUM_EVENTS-1:0] rise;
    logic [NUM_EVENTS-1:0] new_ev;
    logic [NUM_EVENTS-1:0] ack_oh;
    logic [NUM_EVENTS-1:0] clr;
    logic [NUM_EVENTS-1:0] pending_n;
    logic [NUM_EVENTS-1:0] active;

    assign paddr      = apb.PADDR;
    assign idx        = paddr[4:2];
    assign acc_wr     = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign acc_rd     = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign wdata      = apb.PWDATA[NUM_EVENTS-1:0];
    assign unused_apb = ^{paddr, apb.PWDATA};

    // Pending update: new edges/SET always win over W1C and ack clears.
    always_comb begin
        ack_oh = '0;
        for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            ack_oh[i] = irq_ack_i && (irq_id_i == ID_W'(i));
        end
        rise      = events_i & ~evt_q;
        new_ev    = rise | ((acc_wr && idx == A_SET) ? wdata : '0);
        clr       = ((acc_wr && idx == A_PENDING) ? wdata : '0) | ack_oh;
        pending_n = new_ev | (pending_q & ~clr);
    end

    // Lowest set index wins; scanning downward lets the last hit be the smallest.
    always_comb begin
        active   = pending_q & irq_mask_q;
        irq_o    = |active;
        irq_id_o = '0;
        for (int i = int'(NUM_EVENTS) - 1; i >= 0; i--) begin
            if (active[i]) irq_id_o = ID_W'(i);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            evt_q      <= '0;
            pending_q  <= '0;
            irq_mask_q <= '0;
            evt_mask_q <= '0;
            event_q    <= 1'b0;
        end else begin
            evt_q     <= events_i;
            pending_q <= pending_n;
            event_q   <= |(new_ev & evt_mask_q);
            if (acc_wr && idx == A_IRQ_MASK) irq_mask_q <= wdata;
            if (acc_wr && idx == A_EVT_MASK) evt_mask_q <= wdata;
        end
    end

    assign event_o = event_q;

    // Read mux; idle or write cycles return zero.
    always_comb begin
        rdata = '0;
        if (acc_rd) begin
            case (idx)
                A_IRQ_MASK: rdata = DATA_W'(irq_mask_q);
                A_EVT_MASK: rdata = DATA_W'(evt_mask_q);
                A_PENDING:  rdata = DATA_W'(pending_q);
                A_IRQ_ID:   rdata = {irq_o, PAD_W'(0), 8'(irq_id_o)};
                default:    rdata = '0;
            endcase
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
endmodule

// File: tb/tb_event_irq_ctrl.sv
// Table-driven bench for event_irq_ctrl with a per-cycle output scoreboard.
module tb_event_irq_ctrl;
    localparam int unsigned AW = 12;
    localparam int unsigned N  = 12;
    localparam int unsigned IW = 4;

    logic          HCLK;
    logic          HRESETn;
    logic [N-1:0]  events;
    logic          irq_ack;
    logic [IW-1:0] irq_id_in;
    logic          irq_o;
    logic [IW-1:0] irq_id_o;
    logic          event_o;

    event_irq_ctrl_if #(.APB_ADDR_WIDTH(AW)) apb ();

    event_irq_ctrl #(.APB_ADDR_WIDTH(AW), .NUM_EVENTS(N)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .apb      (apb),
        .events_i (events),
        .irq_ack_i(irq_ack),
        .irq_id_i (irq_id_in),
        .irq_o    (irq_o),
        .irq_id_o (irq_id_o),
        .event_o  (event_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        string         name;
        bit            acc;
        bit            wr;
        logic [2:0]    idx;
        logic [31:0]   wdata;
        logic [N-1:0]  ev;
        bit            ack;
        logic [IW-1:0] aid;
        logic [31:0]   exp_rd;   // PRDATA during the cycle, before the edge
        logic          exp_irq;  // outputs after the edge
        logic [IW-1:0] exp_id;
        logic          exp_evt;
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input bit acc, input bit wr, input logic [2:0] idx,
                                input logic [31:0] wdata, input logic [N-1:0] ev, input bit ack,
                                input logic [IW-1:0] aid, input logic [31:0] exp_rd,
                                input logic irq, input logic [IW-1:0] id, input logic evt);
        vec_t v;
        v.name = name; v.acc = acc; v.wr = wr; v.idx = idx; v.wdata = wdata; v.ev = ev;
        v.ack = ack; v.aid = aid; v.exp_rd = exp_rd; v.exp_irq = irq; v.exp_id = id; v.exp_evt = evt;
        return v;
    endfunction

    function automatic vec_t wr_v(input string name, input logic [2:0] idx, input logic [31:0] d,
                                  input logic [N-1:0] ev, input logic irq, input logic [IW-1:0] id,
                                  input logic evt);
        return mk(name, 1'b1, 1'b1, idx, d, ev, 1'b0, '0, 32'h0, irq, id, evt);
    endfunction

    function automatic vec_t rd_v(input string name, input logic [2:0] idx, input logic [N-1:0] ev,
                                  input logic [31:0] rd, input logic irq, input logic [IW-1:0] id,
                                  input logic evt);
        return mk(name, 1'b1, 1'b0, idx, 32'h0, ev, 1'b0, '0, rd, irq, id, evt);
    endfunction

    function automatic vec_t idle_v(input string name, input logic [N-1:0] ev, input bit ack,
                                    input logic [IW-1:0] aid, input logic irq,
                                    input logic [IW-1:0] id, input logic evt);
        return mk(name, 1'b0, 1'b0, 3'd0, 32'h0, ev, ack, aid, 32'h0, irq, id, evt);
    endfunction

    task automatic bus_idle();
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;
        irq_ack = 1'b0; irq_id_in = '0;
    endtask

    // Drive one vector for one cycle and queue its post-edge expectations.
    task automatic apply(input vec_t v);
        @(negedge HCLK);
        apb.PSEL    = v.acc;
        apb.PENABLE = v.acc;
        apb.PWRITE  = v.wr;
        apb.PADDR   = {7'b0, v.idx, 2'b00};
        apb.PWDATA  = v.wdata;
        events      = v.ev;
        irq_ack     = v.ack;
        irq_id_in   = v.aid;
        sb.push_back(v);
        #1;
        chk({v.name, "_prdata"}, apb.PRDATA, v.exp_rd);
    endtask

    initial begin : checker_proc
        vec_t e;
        forever begin
            @(posedge HCLK);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, "_irq"}, 32'(irq_o), 32'(e.exp_irq));
                chk({e.name, "_id"}, 32'(irq_id_o), 32'(e.exp_id));
                chk({e.name, "_evt"}, 32'(event_o), 32'(e.exp_evt));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        HRESETn = 1'b0;
        events  = '0;
        bus_idle();

        // Reset: edge detect, pulse and hold
        vt.push_back(wr_v  ("t1_evtmask", 3'd1, 32'h1, 12'h000, 0, 0, 0));
        vt.push_back(idle_v("t1_rise", 12'h001, 0, 0, 0, 0, 1));
        for (int i = 0; i < 8; i++) vt.push_back(idle_v("t1_hold", 12'h001, 0, 0, 0, 0, 0));
        vt.push_back(rd_v  ("t1_pend", 3'd2, 12'h001, 32'h1, 0, 0, 0));
        vt.push_back(rd_v  ("t1_irqid", 3'd4, 12'h001, 32'h0, 0, 0, 0));
        vt.push_back(wr_v  ("t1_w1c", 3'd2, 32'h1, 12'h000, 0, 0, 0));
        // SET, priority and ack
        vt.push_back(wr_v  ("t2_mask", 3'd0, 32'h30, 12'h000, 0, 0, 0));
        vt.push_back(wr_v  ("t2_set20", 3'd3, 32'h20, 12'h000, 1, 5, 0));
        vt.push_back(wr_v  ("t2_set10", 3'd3, 32'h10, 12'h000, 1, 4, 0));
        vt.push_back(rd_v  ("t2_pend", 3'd2, 12'h000, 32'h30, 1, 4, 0));
        vt.push_back(idle_v("t2_ack4", 12'h000, 1, 4, 1, 5, 0));
        vt.push_back(idle_v("t2_ack5", 12'h000, 1, 5, 0, 0, 0));
        // Ack colliding with a new edge keeps the bit pending
        vt.push_back(wr_v  ("t3_mask", 3'd0, 32'h08, 12'h000, 0, 0, 0));
        vt.push_back(idle_v("t3_edge", 12'h008, 0, 0, 1, 3, 0));
        vt.push_back(idle_v("t3_low", 12'h000, 0, 0, 1, 3, 0));
        vt.push_back(idle_v("t3_ackedge", 12'h008, 1, 3, 1, 3, 0));
        vt.push_back(rd_v  ("t3_pend", 3'd2, 12'h008, 32'h8, 1, 3, 0));
        vt.push_back(idle_v("t3_ack_oor", 12'h008, 1, 12, 1, 3, 0));
        vt.push_back(idle_v("t3_ack3", 12'h008, 1, 3, 0, 0, 0));
        // Masked pending, late unmask, W1C
        vt.push_back(wr_v  ("t4_mask0", 3'd0, 32'h0, 12'h000, 0, 0, 0));
        vt.push_back(idle_v("t4_edge7", 12'h080, 0, 0, 0, 0, 0));
        vt.push_back(rd_v  ("t4_pend", 3'd2, 12'h080, 32'h80, 0, 0, 0));
        vt.push_back(wr_v  ("t4_unmask", 3'd0, 32'h80, 12'h080, 1, 7, 0));
        vt.push_back(rd_v  ("t4_irqid", 3'd4, 12'h080, 32'h8000_0007, 1, 7, 0));
        vt.push_back(wr_v  ("t4_w1c", 3'd2, 32'h80, 12'h080, 0, 0, 0));
        vt.push_back(rd_v  ("t4_irqid0", 3'd4, 12'h080, 32'h0, 0, 0, 0));
        // Back-to-back event pulses on different lines, masked line gives none
        vt.push_back(wr_v  ("b2b_mask", 3'd1, 32'h3, 12'h000, 0, 0, 0));
        vt.push_back(idle_v("b2b_l0", 12'h001, 0, 0, 0, 0, 1));
        vt.push_back(idle_v("b2b_l1", 12'h003, 0, 0, 0, 0, 1));
        vt.push_back(idle_v("b2b_hold", 12'h003, 0, 0, 0, 0, 0));
        vt.push_back(idle_v("b2b_l2m", 12'h004, 0, 0, 0, 0, 0));
        // Unmapped and write-only indices
        vt.push_back(rd_v  ("t5_rd5", 3'd5, 12'h004, 32'h0, 0, 0, 0));
        vt.push_back(rd_v  ("t5_rd6", 3'd6, 12'h004, 32'h0, 0, 0, 0));
        vt.push_back(rd_v  ("t5_rd7", 3'd7, 12'h004, 32'h0, 0, 0, 0));
        vt.push_back(rd_v  ("t5_rdset", 3'd3, 12'h004, 32'h0, 0, 0, 0));
        vt.push_back(wr_v  ("t5_wr6", 3'd6, 32'hFFFF_FFFF, 12'h004, 0, 0, 0));
        vt.push_back(rd_v  ("t5_irqmask", 3'd0, 12'h004, 32'h80, 0, 0, 0));
        vt.push_back(rd_v  ("t5_evtmask", 3'd1, 12'h004, 32'h3, 0, 0, 0));
        vt.push_back(rd_v  ("t5_pend", 3'd2, 12'h004, 32'h7, 0, 0, 0));
        // Register bits above NUM_EVENTS-1
        vt.push_back(wr_v  ("w_w1c_all", 3'd2, 32'hFFFF_FFFF, 12'h004, 0, 0, 0));
        vt.push_back(rd_v  ("w_pend0", 3'd2, 12'h004, 32'h0, 0, 0, 0));
        vt.push_back(wr_v  ("w_mask_all", 3'd0, 32'hFFFF_FFFF, 12'h004, 0, 0, 0));
        vt.push_back(rd_v  ("w_mask_rd", 3'd0, 12'h004, 32'hFFF, 0, 0, 0));
        vt.push_back(wr_v  ("w_set_all", 3'd3, 32'hFFFF, 12'h004, 1, 0, 1));
        vt.push_back(rd_v  ("w_pend_all", 3'd2, 12'h004, 32'hFFF, 1, 0, 0));
        vt.push_back(rd_v  ("w_irqid", 3'd4, 12'h004, 32'h8000_0000, 1, 0, 0));
        vt.push_back(idle_v("w_ack0", 12'h004, 1, 0, 1, 1, 0));
        vt.push_back(idle_v("w_ack11", 12'h004, 1, 11, 1, 1, 0));
        vt.push_back(rd_v  ("w_pend_7fe", 3'd2, 12'h004, 32'h7FE, 1, 1, 0));

        // Reset state
        repeat (2) @(negedge HCLK);
        apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PADDR = 12'h008;
        #1;
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_id", 32'(irq_id_o), 32'h0);
        chk("rst_evt", 32'(event_o), 32'h0);
        chk("rst_prdata", apb.PRDATA, 32'h0);
        chk("rst_pready", 32'(apb.PREADY), 32'h1);
        chk("rst_pslverr", 32'(apb.PSLVERR), 32'h0);
        @(negedge HCLK);
        bus_idle();
        HRESETn = 1'b1;

        for (int i = 0; i < vt.size(); i++) apply(vt[i]);

        // Setup phase only: no read data
        @(negedge HCLK);
        bus_idle();
        apb.PSEL = 1'b1; apb.PADDR = 12'h008;
        #1;
        chk("setup_prdata", apb.PRDATA, 32'h0);
        chk("setup_pslverr", 32'(apb.PSLVERR), 32'h0);

        // Asynchronous reset with irq active and a line held high through release
        @(negedge HCLK);
        bus_idle();
        events  = 12'h001;
        HRESETn = 1'b0;
        #1;
        chk("arst_irq", 32'(irq_o), 32'h0);
        chk("arst_id", 32'(irq_id_o), 32'h0);
        chk("arst_evt", 32'(event_o), 32'h0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PADDR = 12'h008;
        #1;
        chk("arst_pend0", apb.PRDATA, 32'h0);
        @(negedge HCLK);
        #1;
        chk("arst_firstedge", apb.PRDATA, 32'h1);
        chk("arst_irq_masked", 32'(irq_o), 32'h0);
        @(negedge HCLK);
        apb.PADDR = 12'h000;
        #1;
        chk("arst_irqmask", apb.PRDATA, 32'h0);
        @(negedge HCLK);
        bus_idle();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0 entries", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
